display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter PRESCALE, default 4096: clock cycles per digit slot, legal range 2..65535.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1: when 1, seg and an are driven active-low (common-anode); when 0, active-high.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  scan enable; 0 blanks the display.
REQ-006 SHALL have ports dig0..dig3  input  4 each  BCD digits from the timer counters (bit3 = A = MSB, bit0 = D = LSB); dig0 is units of seconds, dig3 is tens of minutes.
REQ-007 SHALL have port seg  output  7  segment drive, seg[6]=a .. seg[0]=g.
REQ-008 SHALL have port an  output  4  digit select, an[i] lights digit i.

Function
REQ-009 SHALL hold slot counter cnt (0..PRESCALE-1) and digit index idx (0..3); with en=1, cnt increments each cycle; at cnt=PRESCALE-1, cnt wraps to 0 and idx advances modulo 4 (3 -> 0).
REQ-010 SHALL operate a two-state FSM per slot: BLANK when cnt=0 (all anodes off, all segments off), SHOW when cnt>=1 (anode idx on, seg = decode of snapshot digit idx).
REQ-011 SHALL load all four dig inputs into a snapshot register on the edge ending the cycle with idx=0 and cnt=0, so a whole frame displays one coherent time value; inputs are ignored at all other times.
REQ-012 SHALL register seg and an: outputs in cycle k+1 reflect FSM state of cycle k (one-cycle latency).
REQ-013 SHALL decode BCD using standard 7-segment patterns (1 = b,c; 7 = a,b,c; 6 = a,c,d,e,f,g; 9 = a,b,c,d,f,g); codes 10..15 SHALL show a dash (g only).
REQ-014 SHALL assert at most one an bit in any cycle, and none during BLANK.
REQ-015 SHALL, when en=0, force cnt=0, idx=0, FSM BLANK on the next edge; outputs blank one cycle later.
REQ-016 SHALL, when en returns to 1, restart at digit 0 with a fresh snapshot, exactly as after reset.
REQ-017 SHALL give clear priority over en when both are active.

Reset
REQ-018 SHALL, on clear=1 at an edge, set cnt=0, idx=0, FSM BLANK, snapshot=0, seg all off, an all off (off = per ACTIVE_LOW polarity).
REQ-019 SHALL, on clear asserted mid-slot, abandon the slot without completing it; the next scan starts at digit 0.

Configuration
REQ-020 SHALL support macro DISPLAY_SCAN_LZB_EN: when defined, digit 3 is blanked (segments off, anode still follows scan timing) if its snapshot value is 0; when undefined, digit 3 shows 0 normally.

Structure
REQ-021 SHALL place the FSM state enum, 7-bit segment pattern constants (digits 0..9, dash, off) and the 2-bit digit-index type in package display_scan_pkg.
REQ-022 SHALL instantiate one combinational sub-module bcd_to_seg7 (4-bit BCD in, 7-bit active-high pattern out); polarity inversion happens only in display_scan.

Verification (PRESCALE=4, ACTIVE_LOW=0 unless stated)
REQ-023 Reset then en=1, dig0..3 = 3,2,1,4 -> cycles 2..4 an=0001 seg=1111001 (3); cycle 5 an=0000; cycles 6..8 an=0010 seg=1101101 (2); digit 3 shows seg=0110011 (4) in cycles 14..16.
REQ-024 Change dig0 from 3 to 8 at cycle 6 -> digit 0 keeps showing 3 until the next frame; seg=1111111 (8) first appears in cycle 18.
REQ-025 dig1 = 4'b1100 -> digit 1 slot shows seg=0000001 (dash).
REQ-026 Drop en at cycle 7 for 3 cycles -> an=0000 from cycle 8; after en returns, first lit digit is digit 0 with newly sampled values, two cycles after the first enabled cycle.
REQ-027 dig3=0 with DISPLAY_SCAN_LZB_EN defined -> digit 3 slot seg=0000000, an=1000; without macro -> seg=1111110.
REQ-028 ACTIVE_LOW=1 with clear held -> seg=1111111, an=1111; assertion every cycle: at most one an bit active.

Source files
------------

// File: rtl/display_scan_pkg.sv
// display_scan_pkg: shared types and constants for the 4-digit multiplexed
// seven-segment scanner (scan FSM states, digit index type, segment patterns).
// Segment patterns are active-high with bit 6 = a ... bit 0 = g.
package display_scan_pkg;

    // Width of the per-slot prescale counter (covers PRESCALE up to 65535)
    localparam int CNT_W = 16;

    // Per-slot scan state: BLANK on the first cycle of a slot, SHOW afterwards
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Index of the digit currently being scanned (0 = units of seconds)
    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-high seven-segment decoder.
// Codes 10..15 are not valid BCD and are shown as a dash.
module bcd_to_seg7
    import display_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Map each BCD code to its segment pattern
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed driver for a 4-digit seven-segment display.
// Each digit gets a slot of PRESCALE cycles; the first cycle of every slot is
// blanked to avoid ghosting. All four digits are captured together at the
// start of a frame so one frame always shows a coherent time value.
// Optional feature macro: DISPLAY_SCAN_LZB_EN (blank a leading zero on digit 3).
module display_scan
    import display_scan_pkg::*;
#(
    parameter int PRESCALE   = 4096,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Physical "off" levels depend on the drive polarity of the board
    localparam logic [6:0] SEG_IDLE = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [3:0] AN_IDLE  = ACTIVE_LOW ? 4'b1111 : 4'b0000;

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    digit_idx_t        idx_q,   idx_d;
    scan_state_e       state_q, state_d;
    logic [3:0][3:0]   snap_q,  snap_d;
    logic [6:0]        seg_q,   seg_d;
    logic [3:0]        an_q,    an_d;
    logic [3:0]        cur_digit_s;
    logic [6:0]        dec_pat_s;
    logic [6:0]        lit_pat_s;
    logic [3:0]        lit_an_s;

    assign cur_digit_s = snap_q[idx_q];

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit_s),
        .seg_o (dec_pat_s)
    );

    // Slot counter, digit index, scan state and frame snapshot next-state
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        state_d = ST_BLANK;
        if (!en) begin
            cnt_d = CNT_ZERO;
            idx_d = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            idx_d = idx_q;
        end
        if (cnt_d != CNT_ZERO) begin
            state_d = ST_SHOW;
        end else begin
            state_d = ST_BLANK;
        end
        // Capture only on the first cycle of a frame
        if (en && (cnt_q == CNT_ZERO) && (idx_q == 2'd0)) begin
            snap_d = {dig3, dig2, dig1, dig0};
        end else begin
            snap_d = snap_q;
        end
    end

    // Output pattern for the current scan state, then polarity applied
    always_comb begin
        lit_pat_s = SEG_OFF;
        lit_an_s  = 4'b0000;
        if (en && (state_q == ST_SHOW)) begin
            lit_an_s = 4'b0001 << idx_q;
`ifdef DISPLAY_SCAN_LZB_EN
            if ((idx_q == 2'd3) && (cur_digit_s == 4'd0)) begin
                lit_pat_s = SEG_OFF;
            end else begin
                lit_pat_s = dec_pat_s;
            end
`else
            lit_pat_s = dec_pat_s;
`endif
        end else begin
            lit_pat_s = SEG_OFF;
            lit_an_s  = 4'b0000;
        end
        seg_d = ACTIVE_LOW ? ~lit_pat_s : lit_pat_s;
        an_d  = ACTIVE_LOW ? ~lit_an_s  : lit_an_s;
    end

    // State, snapshot and registered outputs with synchronous clear
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q   <= CNT_ZERO;
            idx_q   <= 2'd0;
            state_q <= ST_BLANK;
            snap_q  <= 16'h0000;
            seg_q   <= SEG_IDLE;
            an_q    <= AN_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed test of display_scan with PRESCALE=4.
// Two instances share stimulus: one active-high, one active-low; the
// active-low instance is expected to show the bitwise inverse.
module tb_display_scan;

    logic       clk = 1'b0;
    logic       clear;
    logic       en;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [6:0] seg_h, seg_l;
    logic [3:0] an_h, an_l;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    localparam logic [6:0] P_OFF  = 7'b0000000;
    localparam logic [6:0] P_0    = 7'b1111110;
    localparam logic [6:0] P_1    = 7'b0110000;
    localparam logic [6:0] P_2    = 7'b1101101;
    localparam logic [6:0] P_3    = 7'b1111001;
    localparam logic [6:0] P_4    = 7'b0110011;
    localparam logic [6:0] P_5    = 7'b1011011;
    localparam logic [6:0] P_6    = 7'b1011111;
    localparam logic [6:0] P_7    = 7'b1110000;
    localparam logic [6:0] P_8    = 7'b1111111;
    localparam logic [6:0] P_9    = 7'b1111011;
    localparam logic [6:0] P_DASH = 7'b0000001;
`ifdef DISPLAY_SCAN_LZB_EN
    localparam logic [6:0] P_D3ZERO = 7'b0000000;
`else
    localparam logic [6:0] P_D3ZERO = 7'b1111110;
`endif

    display_scan #(.PRESCALE(4), .ACTIVE_LOW(1'b0)) u_dut_h (
        .clk(clk), .clear(clear), .en(en),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .seg(seg_h), .an(an_h)
    );

    display_scan #(.PRESCALE(4), .ACTIVE_LOW(1'b1)) u_dut_l (
        .clk(clk), .clear(clear), .en(en),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .seg(seg_l), .an(an_l)
    );

    always #5 clk = ~clk;

    // Advance one clock, sample just after the edge, check anode exclusivity
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        assert (($countones(an_h) <= 1) && ($countones(~an_l) <= 1)) else begin
            errors++;
            $error("FAIL onehot cyc=%0d: observed an_h=%b an_l=%b expected at most one active", cyc, an_h, an_l);
        end
    endtask

    task automatic go(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        checks++;
        assert (an_h === exp_an && seg_h === exp_seg) else begin
            errors++;
            $error("FAIL %s (high): observed an=%b seg=%b expected an=%b seg=%b", tag, an_h, seg_h, exp_an, exp_seg);
        end
        checks++;
        assert (an_l === ~exp_an && seg_l === ~exp_seg) else begin
            errors++;
            $error("FAIL %s (low): observed an=%b seg=%b expected an=%b seg=%b", tag, an_l, seg_l, ~exp_an, ~exp_seg);
        end
    endtask

    initial begin
        clear = 1'b1; en = 1'b0;
        dig0 = 4'd0; dig1 = 4'd0; dig2 = 4'd0; dig3 = 4'd0;
        tick(); tick();
        chk("reset", 4'b0000, P_OFF);

        // Frame 1: 3,2,1,4
        clear = 1'b0; en = 1'b1;
        dig0 = 4'd3; dig1 = 4'd2; dig2 = 4'd1; dig3 = 4'd4;
        cyc = 0;
        go(1);  chk("c1_blank", 4'b0000, P_OFF);
        go(2);  chk("d0_c2", 4'b0001, P_3);
        go(4);  chk("d0_c4", 4'b0001, P_3);
        go(5);  chk("slot_gap", 4'b0000, P_OFF);
        go(6);  dig0 = 4'd8;
                chk("d1_c6", 4'b0010, P_2);
        go(8);  chk("d1_c8", 4'b0010, P_2);
        go(10); dig1 = 4'b1100; dig3 = 4'd0;
                chk("d2_c10", 4'b0100, P_1);
        go(14); chk("d3_c14", 4'b1000, P_4);
        go(16); chk("d3_c16", 4'b1000, P_4);
        go(17); chk("frame_gap", 4'b0000, P_OFF);
        // Frame 2: snapshot 8,dash,1,0
        go(18); chk("d0_new8", 4'b0001, P_8);
        go(22); chk("d1_dash", 4'b0010, P_DASH);
        go(29); chk("c29_blank", 4'b0000, P_OFF);
        go(30); chk("d3_zero", 4'b1000, P_D3ZERO);
        clear = 1'b1;                       // mid-slot, en still high
        go(31); chk("clear_mid", 4'b0000, P_OFF);

        // Restart: 5,6,7,9 then en drop
        clear = 1'b0; en = 1'b1;
        dig0 = 4'd5; dig1 = 4'd6; dig2 = 4'd7; dig3 = 4'd9;
        cyc = 0;
        go(2);  chk("r_d0", 4'b0001, P_5);
        go(6);  chk("r_d1", 4'b0010, P_6);
        go(7);  chk("r_d1_c7", 4'b0010, P_6);
                en = 1'b0; dig0 = 4'd9;
        go(8);  chk("en_off_c8", 4'b0000, P_OFF);
        go(9);  chk("en_off_c9", 4'b0000, P_OFF);
        go(10); en = 1'b1;
                chk("en_on_c10", 4'b0000, P_OFF);
        go(11); chk("en_on_c11", 4'b0000, P_OFF);
        go(12); chk("en_on_d0", 4'b0001, P_9);
        go(16); chk("en_on_d1", 4'b0010, P_6);
        go(20); chk("en_on_d2", 4'b0100, P_7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
